if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the five-stage RISC-V core; the sole master of the scratch-pad memory's IF (A) port. Keeps the PC, drives a word read address to the SPM every cycle, aligns the SPM's one-cycle registered read data with its PC, and presents it to the ID stage. A one-entry hold buffer keeps the IF/ID output stable across stalls, because the SPM read data register updates every clock.

## Interface
- `RESET_VECTOR`, default 32'h0000_0000: PC loaded at reset; bits [1:0] ignored.
- `clk` in 1: core clock. Single clock domain.
- `reset` in 1: synchronous, active-high.
- `stall` in 1: ID cannot accept this cycle; hold the IF/ID outputs.
- `flush` in 1: pipeline flush (exception or trap return); redirect to `new_pc`.
- `new_pc` in 32: flush target.
- `br_taken` in 1: taken branch or jump resolved in ID.
- `br_addr` in 32: branch target.
- `if_spm_addr` out 32: SPM word address, {2'b00, pc[31:2]}.
- `if_spm_as_` out 1: address strobe, active-low.
- `if_spm_rw` out 1: constant `READ`.
- `if_spm_wr_data` out 32: constant 0.
- `if_spm_rd_data` in 32: SPM data, registered, valid one cycle after the address.
- `if_pc` out 32: PC of `if_insn`.
- `if_insn` out 32: fetched instruction, or NOP 32'h0000_0013 when `if_en`=0.
- `if_en` out 1: `if_pc`/`if_insn` hold a valid instruction.

## Operation
- Registers:
  - `pc`: next address to issue.
  - `if_pc`, `if_en`: IF/ID outputs.
  - `hold_insn`, `hold_vld`: hold buffer.
- Combinational outputs:
  - `if_spm_addr` is driven from `pc`.
  - `if_spm_as_` = 1 when `reset` or `stall` is asserted, else 0.
  - `if_insn` = NOP if !`if_en`; else `hold_insn` if `hold_vld`; else `if_spm_rd_data`.
- Per-edge priority: `reset` > `flush` > `stall` > `br_taken` > normal.
  - **reset**: `pc` <= RESET_VECTOR & ~3. `if_pc` <= 0, `if_en` <= 0, `hold_vld` <= 0, `hold_insn` <= 0.
  - **flush**: `pc` <= `new_pc` & ~3. `if_en` <= 0, `hold_vld` <= 0. Overrides `stall`.
  - **stall**: `pc`, `if_pc` and `if_en` unchanged. If `hold_vld`=0, then `hold_insn` <= `if_spm_rd_data` and `hold_vld` <= 1. If `hold_vld`=1, the buffer is unchanged.
  - **br_taken**: `pc` <= `br_addr` & ~3. `if_en` <= 0 (one bubble), `hold_vld` <= 0.
  - **normal**: `if_pc` <= `pc`, `if_en` <= 1, `pc` <= `pc` + 4, `hold_vld` <= 0.
- Arithmetic and alignment:
  - `pc` + 4 is 32-bit and wraps from 32'hFFFF_FFFC to 0.
  - Low two bits of every loaded PC are forced to 0; no misalignment fault is raised.
- State view: FETCH (`hold_vld`=0) and HOLD (`hold_vld`=1).
  - FETCH→HOLD on `stall`.
  - HOLD→FETCH on !`stall` or on `flush`.
  - `br_taken` has no effect while `stall` is asserted.

## Timing
- Fetch latency: an address is driven in cycle N; the matching `if_pc`/`if_insn`/`if_en` are valid in cycle N+1.
- Throughput: one instruction per cycle when unstalled.
- Reset release: the first valid instruction (`if_pc` = RESET_VECTOR) appears 2 cycles after the reset edge.
- Redirect penalty:
  - Flush: `if_en`=0 for exactly 1 cycle, then target valid.
  - Branch: the same, `if_en`=0 for 1 cycle, then target valid.
- Stall behaviour: outputs stay bit-identical for every stalled cycle. On the release cycle, `if_insn` comes from the hold buffer; the next cycle shows mem[`pc`].
- SPM writes from the MEM port to an address already held are not re-fetched; the stale instruction is used.

## Structure
- Shared header constants: `ENABLE_`/`DISABLE_`, `READ`/`WRITE`, `NOP_INSN` (32'h0000_0013), `WORD_ADDR_LSB` (2).
- Sub-module `if_hold_buf`: the 32-bit hold register plus valid flag and output mux. Inputs: capture, clear, rd_data. Output: selected instruction.
- Top level contains the PC logic and the IF/ID registers; roughly 150–200 lines of RTL total.

## Test plan
- **Reset**: RESET_VECTOR=32'h100, SPM preloaded with word i = i.
  - During reset: `if_en`=0, `if_insn`=32'h13, `if_spm_as_`=1.
  - Then `if_pc` = 0x100, 0x104, 0x108 with `if_insn` = 0x40, 0x41, 0x42 on consecutive cycles.
- **Stall**: `stall`=1 for 3 cycles while `if_pc`=0x104.
  - `if_pc`/`if_insn` stay 0x104/0x41 for 4 cycles total.
  - Next cycles show 0x108/0x42.
- **Branch**: `br_taken`=1, `br_addr`=0x203 while `if_pc`=0x108.
  - Next cycle `if_en`=0.
  - Following cycle `if_pc`=0x200, `if_insn`=0x80.
- **Flush during stall**: `flush`=1, `new_pc`=0x10, `stall`=1 in the same cycle while in HOLD.
  - `hold_vld` clears.
  - After `stall` drops: `if_en`=0 for one cycle, then `if_pc`=0x10, `if_insn`=0x4.
- **Wrap**: `br_addr`=0xFFFF_FFFC.
  - `if_pc` = 0xFFFF_FFFC, then 0x0.
  - `if_spm_addr` = 0x3FFF_FFFF, then 0.
- **Reset mid-stall**: `reset` asserted with `hold_vld`=1.
  - Next cycle: all outputs at reset values, `hold_vld`=0.
  - Fetch restarts at RESET_VECTOR.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared constants, state type and address helpers for the instruction-fetch stage.
// Imported by if_stage and if_hold_buf.
package if_stage_pkg;

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;
    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;

    localparam logic [31:0] NOP_INSN      = 32'h0000_0013;
    localparam int          WORD_ADDR_LSB = 2;

    // FETCH: IF/ID shows live SPM data; HOLD: IF/ID shows the captured word.
    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } if_state_e;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

    function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
        return byte_addr >> WORD_ADDR_LSB;
    endfunction

endpackage

// File: rtl/if_hold_buf.sv
// One-entry hold buffer: keeps the instruction stable while ID stalls, because the
// SPM read data register keeps updating every clock.
module if_hold_buf
    import if_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        capture,
    input  logic        clear,
    input  logic [31:0] rd_data,
    output logic [31:0] insn,
    output logic        hold_vld,
    output if_state_e   state
);

    if_state_e   state_q;
    if_state_e   state_d;
    logic [31:0] hold_insn;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   if (capture) state_d = HOLD;
            HOLD:    if (clear)   state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    // Only the first stalled cycle captures; later stall cycles keep that word.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_insn <= 32'h0;
        end else if (state_q == FETCH && capture) begin
            hold_insn <= rd_data;
        end
    end

    always_comb begin
        hold_vld = (state_q == HOLD);
        state    = state_q;
        insn     = hold_vld ? hold_insn : rd_data;
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the SPM A-port read address and
// presents the PC-aligned instruction to ID through the IF/ID registers.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic        br_taken,
    input  logic [31:0] br_addr,
    output logic [31:0] if_spm_addr,
    output logic        if_spm_as_,
    output logic        if_spm_rw,
    output logic [31:0] if_spm_wr_data,
    input  logic [31:0] if_spm_rd_data,
    output logic [31:0] if_pc,
    output logic [31:0] if_insn,
    output logic        if_en,
    output if_state_e   dbg_state
);

    logic [31:0] pc;
    logic [31:0] buf_insn;
    logic        hold_vld;
    logic        buf_capture;
    logic        buf_clear;

    // IF/ID handshake: if_en is the valid flag, !stall is ready. An instruction
    // moves to ID on an edge with if_en=1 and stall=0; while stall=1 every IF/ID
    // output is held bit-identical, and a flush drops whatever is presented.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc    <= align_pc(RESET_VECTOR);
            if_pc <= 32'h0;
            if_en <= 1'b0;
        end else if (flush) begin
            pc    <= align_pc(new_pc);
            if_en <= 1'b0;
        end else if (stall) begin
            pc    <= pc;
            if_en <= if_en;
        end else if (br_taken) begin
            pc    <= align_pc(br_addr);
            if_en <= 1'b0;
        end else begin
            if_pc <= pc;
            if_en <= 1'b1;
            pc    <= pc + 32'd4;
        end
    end

    // A flush wins over a stall, so the captured word is discarded on redirect.
    assign buf_capture = stall && !flush;
    assign buf_clear   = flush || !stall;

    if_hold_buf u_hold_buf (
        .clk      (clk),
        .reset    (reset),
        .capture  (buf_capture),
        .clear    (buf_clear),
        .rd_data  (if_spm_rd_data),
        .insn     (buf_insn),
        .hold_vld (hold_vld),
        .state    (dbg_state)
    );

    always_comb begin
        if_spm_addr    = word_addr(pc);
        if_spm_as_     = (reset || stall) ? DISABLE_ : ENABLE_;
        if_spm_rw      = READ;
        if_spm_wr_data = 32'h0;
        if (!if_en) begin
            if_insn = NOP_INSN;
        end else if (hold_vld) begin
            if_insn = buf_insn;
        end else begin
            if_insn = if_spm_rd_data;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed vector table, hand-written corner
// sequences, then randomized traffic against a PC-level reference model.
module tb_if_stage;
    import if_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] new_pc = 32'h0;
    logic        br_taken = 1'b0;
    logic [31:0] br_addr = 32'h0;
    logic [31:0] if_spm_addr;
    logic        if_spm_as_;
    logic        if_spm_rw;
    logic [31:0] if_spm_wr_data;
    logic [31:0] if_spm_rd_data = 32'h0;
    logic [31:0] if_pc;
    logic [31:0] if_insn;
    logic        if_en;
    if_state_e   dbg_state;

    logic [31:0] salt = 32'h0;
    int          n_vec  = 0;
    int          n_fail = 0;

    if_stage #(.RESET_VECTOR(32'h0000_0100)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .flush          (flush),
        .new_pc         (new_pc),
        .br_taken       (br_taken),
        .br_addr        (br_addr),
        .if_spm_addr    (if_spm_addr),
        .if_spm_as_     (if_spm_as_),
        .if_spm_rw      (if_spm_rw),
        .if_spm_wr_data (if_spm_wr_data),
        .if_spm_rd_data (if_spm_rd_data),
        .if_pc          (if_pc),
        .if_insn        (if_insn),
        .if_en          (if_en),
        .dbg_state      (dbg_state)
    );

    always #5 clk = ~clk;

    // SPM word i holds i ^ salt; registered read updated every clock.
    function automatic logic [31:0] mem_word(input logic [31:0] idx, input logic [31:0] s);
        return idx ^ s;
    endfunction

    always @(posedge clk) if_spm_rd_data <= mem_word(if_spm_addr, salt);

    typedef struct {
        logic        rst, fl, st, br;
        logic [31:0] npc, baddr;
        logic        e_en;
        logic [31:0] e_pc, e_insn, e_addr;
        logic        e_as, e_hold;
    } vec_t;

    function automatic vec_t mk(input logic rst, fl, st, br, input logic [31:0] npc, baddr,
                                input logic e_en, input logic [31:0] e_pc, e_insn, e_addr,
                                input logic e_as, e_hold);
        vec_t v;
        v.rst = rst; v.fl = fl; v.st = st; v.br = br; v.npc = npc; v.baddr = baddr;
        v.e_en = e_en; v.e_pc = e_pc; v.e_insn = e_insn; v.e_addr = e_addr;
        v.e_as = e_as; v.e_hold = e_hold;
        return v;
    endfunction

    task automatic chk(input string name, input string what, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s %s: got %h expected %h", name, what, act, exp);
        end
    endtask

    // Drive one cycle of inputs after the falling edge, then compare outputs.
    task automatic apply(input vec_t v, input string name);
        @(negedge clk);
        reset = v.rst; flush = v.fl; stall = v.st; br_taken = v.br;
        new_pc = v.npc; br_addr = v.baddr;
        #1;
        chk(name, "if_en", {31'b0, if_en}, {31'b0, v.e_en});
        chk(name, "if_pc", if_pc, v.e_pc);
        chk(name, "if_insn", if_insn, v.e_insn);
        chk(name, "spm_addr", if_spm_addr, v.e_addr);
        chk(name, "spm_as_", {31'b0, if_spm_as_}, {31'b0, v.e_as});
        chk(name, "hold", {31'b0, dbg_state == HOLD}, {31'b0, v.e_hold});
        chk(name, "rw_wd", {if_spm_wr_data[30:0], if_spm_rw}, {31'b0, READ});
    endtask

    vec_t tbl[$];

    // Reference model: PC bookkeeping plus "ID sees memory at if_pc".
    logic [31:0] m_pc, m_if_pc;
    logic        m_en, m_hold;

    task automatic model_step(input vec_t v);
        if (v.rst) begin
            m_pc = 32'h100; m_if_pc = 32'h0; m_en = 1'b0; m_hold = 1'b0;
        end else if (v.fl) begin
            m_pc = v.npc & ~32'h3; m_en = 1'b0; m_hold = 1'b0;
        end else if (v.st) begin
            m_hold = 1'b1;
        end else if (v.br) begin
            m_pc = v.baddr & ~32'h3; m_en = 1'b0; m_hold = 1'b0;
        end else begin
            m_if_pc = m_pc; m_en = 1'b1; m_pc = m_pc + 32'd4; m_hold = 1'b0;
        end
    endtask

    initial begin
        vec_t v;
        repeat (2) @(posedge clk);

        //         rst fl st br npc     baddr      en pc      insn    addr   as hold
        tbl.push_back(mk(1, 0, 0, 0, 32'h0, 32'h0,   0, 32'h0,   32'h13, 32'h40, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0, 32'h0,   0, 32'h0,   32'h13, 32'h40, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0, 32'h0,   1, 32'h100, 32'h40, 32'h41, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 32'h0, 32'h0,   1, 32'h104, 32'h41, 32'h42, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 32'h0, 32'h0,   1, 32'h104, 32'h41, 32'h42, 1, 1));
        tbl.push_back(mk(0, 0, 1, 0, 32'h0, 32'h0,   1, 32'h104, 32'h41, 32'h42, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0, 32'h0,   1, 32'h104, 32'h41, 32'h42, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 32'h0, 32'h203, 1, 32'h108, 32'h42, 32'h43, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0, 32'h0,   0, 32'h108, 32'h13, 32'h80, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 32'h0, 32'h0,   1, 32'h200, 32'h80, 32'h81, 1, 0));
        tbl.push_back(mk(0, 1, 1, 0, 32'h10, 32'h0,  1, 32'h200, 32'h80, 32'h81, 1, 1));
        tbl.push_back(mk(0, 0, 1, 0, 32'h0, 32'h0,   0, 32'h200, 32'h13, 32'h4,  1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0, 32'h0,   0, 32'h200, 32'h13, 32'h4,  0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0, 32'h0,   1, 32'h10,  32'h4,  32'h5,  0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 32'h0, 32'h400, 1, 32'h14,  32'h5,  32'h6,  1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0, 32'h0,   1, 32'h14,  32'h5,  32'h6,  0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0, 32'h0,   1, 32'h18,  32'h6,  32'h7,  0, 0));
        foreach (tbl[i]) apply(tbl[i], $sformatf("tbl%0d", i));

        // PC wrap through the top of the address space.
        apply(mk(0, 0, 0, 1, 32'h0, 32'hFFFF_FFFC, 1, 32'h1C, 32'h7, 32'h8, 0, 0), "wrap0");
        apply(mk(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h1C, 32'h13, 32'h3FFF_FFFF, 0, 0), "wrap1");
        apply(mk(0, 0, 0, 0, 32'h0, 32'h0, 1, 32'hFFFF_FFFC, 32'h3FFF_FFFF, 32'h0, 0, 0), "wrap2");
        apply(mk(0, 0, 0, 0, 32'h0, 32'h0, 1, 32'h0, 32'h0, 32'h1, 0, 0), "wrap3");

        // Reset arriving while the hold buffer is full.
        apply(mk(0, 0, 1, 0, 32'h0, 32'h0, 1, 32'h4, 32'h1, 32'h2, 1, 0), "rmid0");
        apply(mk(1, 0, 1, 0, 32'h0, 32'h0, 1, 32'h4, 32'h1, 32'h2, 1, 1), "rmid1");
        apply(mk(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h13, 32'h40, 0, 0), "rmid2");
        apply(mk(0, 0, 0, 0, 32'h0, 32'h0, 1, 32'h100, 32'h40, 32'h41, 0, 0), "rmid3");

        // Random traffic: resync with an unchecked reset cycle and a new memory image.
        @(negedge clk);
        reset = 1'b1; flush = 1'b0; stall = 1'b0; br_taken = 1'b0;
        salt = $urandom;
        m_pc = 32'h100; m_if_pc = 32'h0; m_en = 1'b0; m_hold = 1'b0;
        for (int i = 0; i < 600; i++) begin
            v.rst   = ($urandom_range(0, 99) < 2);
            v.fl    = ($urandom_range(0, 99) < 6);
            v.st    = ($urandom_range(0, 99) < 25);
            v.br    = ($urandom_range(0, 99) < 15);
            v.npc   = ($urandom_range(0, 3) == 0) ? $urandom : {20'h0, 12'($urandom)};
            v.baddr = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7))
                                                  : $urandom;
            v.e_en   = m_en;
            v.e_pc   = m_if_pc;
            v.e_insn = m_en ? mem_word(m_if_pc >> 2, salt) : NOP_INSN;
            v.e_addr = m_pc >> 2;
            v.e_as   = v.rst | v.st;
            v.e_hold = m_hold;
            apply(v, $sformatf("rnd%0d", i));
            model_step(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
